// File: rtl/sopc_v3_pio_pkg.sv
// Shared constants for the SOPC v3 PIO blocks: Avalon word addresses,
// edge-type encodings and the bus data width.
package sopc_v3_pio_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/sopc_v3_capteur_in_if.sv
// Avalon-MM slave bus of the sensor input port. A write occurs on a rising
// clk edge with chipselect=1 and write_n=0; readdata is valid one edge after address.
interface sopc_v3_capteur_in_if;
  import sopc_v3_pio_pkg::*;

  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/sopc_v3_sync_edge.sv
// Multi-stage input synchronizer with previous-sample flop and per-bit edge pulse.
// Edge logic exists only when SOPC_V3_CAPTEUR_EDGE_IRQ_EN is defined.
module sopc_v3_sync_edge
  import sopc_v3_pio_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= RESET_VALUE;
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

`ifdef SOPC_V3_CAPTEUR_EDGE_IRQ_EN
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= RESET_VALUE;
    else     r_prev <= o_sync;
  end

  always_comb begin
    o_edge = '0;
    case (EDGE_TYPE)
      EDGE_RISE: o_edge = o_sync & ~r_prev;
      EDGE_FALL: o_edge = ~o_sync & r_prev;
      default:   o_edge = o_sync ^ r_prev;
    endcase
  end
`else
  assign o_edge = '0;
`endif

endmodule

// File: rtl/sopc_v3_capteur_in.sv
// Avalon-MM sensor input port: synchronized DATA register, and (with
// SOPC_V3_CAPTEUR_EDGE_IRQ_EN) sticky W1C edge capture, IRQ mask and level irq.
module sopc_v3_capteur_in
  import sopc_v3_pio_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  sopc_v3_capteur_in_if.slave   bus,
  input  logic [WIDTH-1:0]      in_port
);

  logic [WIDTH-1:0]  w_sync;
  logic [WIDTH-1:0]  w_edge;
  logic              w_wr;
  logic [DATA_W-1:0] w_rd_next;
  logic [DATA_W-1:0] r_readdata;

  assign w_wr = bus.chipselect & ~bus.write_n;

  sopc_v3_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync_edge (
    .clk     (clk),
    .rst     (reset),
    .i_async (in_port),
    .o_sync  (w_sync),
    .o_edge  (w_edge)
  );

`ifdef SOPC_V3_CAPTEUR_EDGE_IRQ_EN
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] w_clr;
  logic             w_unused_wdata;

  assign w_clr = (w_wr && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
  assign w_unused_wdata = ^bus.writedata;

  // Set is OR-ed in after the clear so a coincident edge survives the W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irqmask <= '0;
      r_edgecap <= '0;
    end else begin
      if (w_wr && bus.address == ADDR_IRQMASK) r_irqmask <= bus.writedata[WIDTH-1:0];
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
    end
  end

  always_comb begin
    w_rd_next = '0;
    case (bus.address)
      ADDR_DATA:    w_rd_next[WIDTH-1:0] = w_sync;
      ADDR_IRQMASK: w_rd_next[WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: w_rd_next[WIDTH-1:0] = r_edgecap;
      default:      w_rd_next = '0;
    endcase
  end

  assign bus.irq = |(r_edgecap & r_irqmask);
`else
  logic w_unused_bus;

  assign w_unused_bus = ^{bus.writedata, w_wr, w_edge};

  always_comb begin
    w_rd_next = '0;
    if (bus.address == ADDR_DATA) w_rd_next[WIDTH-1:0] = w_sync;
  end

  assign bus.irq = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_readdata <= '0;
    else       r_readdata <= w_rd_next;
  end

  assign bus.readdata = r_readdata;

endmodule

// File: tb/tb_sopc_v3_capteur_in.sv
// Directed bench for sopc_v3_capteur_in: a rising-edge instance and an
// any-edge instance share the same bus stimulus and input lines.
module tb_sopc_v3_capteur_in;
  import sopc_v3_pio_pkg::*;

`ifdef SOPC_V3_CAPTEUR_EDGE_IRQ_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        cs;
  logic        wr_n;
  logic [31:0] wdata;
  logic [3:0]  in_port;
  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1);
  end

  sopc_v3_capteur_in_if bus1 ();
  sopc_v3_capteur_in_if bus2 ();

  assign bus1.address = address;  assign bus2.address = address;
  assign bus1.chipselect = cs;    assign bus2.chipselect = cs;
  assign bus1.write_n = wr_n;     assign bus2.write_n = wr_n;
  assign bus1.writedata = wdata;  assign bus2.writedata = wdata;

  sopc_v3_capteur_in #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISE), .RESET_VALUE(4'hA))
    dut_rise (.clk(clk), .reset(reset), .bus(bus1), .in_port(in_port));
  sopc_v3_capteur_in #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_ANY), .RESET_VALUE(4'hA))
    dut_any (.clk(clk), .reset(reset), .bus(bus2), .in_port(in_port));

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; cs = 1'b1; wr_n = 1'b0; wdata = d;
    tick();
    cs = 1'b0; wr_n = 1'b1; wdata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] r1, output logic [31:0] r2);
    address = a; cs = 1'b1;
    tick();
    cs = 1'b0;
    r1 = bus1.readdata;
    r2 = bus2.readdata;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] r1, r2;
    reset = 1'b1; in_port = 4'hA; address = ADDR_DATA; cs = 1'b0; wr_n = 1'b1; wdata = '0;
    tick(3);
    n_tests++; if (bus1.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %h want 0", bus1.readdata); end
    n_tests++; if (bus1.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", bus1.irq); end
    reset = 1'b0;
    tick(3);
    n_tests++; if (bus1.readdata !== 32'hA) begin n_fail++; $display("FAIL reset_data: got %h want 0000000a", bus1.readdata); end
    bus_read(ADDR_EDGECAP, r1, r2);
    n_tests++; if (r1 !== 32'h0) begin n_fail++; $display("FAIL reset_edgecap: got %h want 0", r1); end
    n_tests++; if (bus1.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq_after: got %b want 0", bus1.irq); end
    bus_read(ADDR_IRQMASK, r1, r2);
    n_tests++; if (r1 !== 32'h0) begin n_fail++; $display("FAIL reset_irqmask: got %h want 0", r1); end
  endtask

  task automatic test_data_path();
    logic [31:0] r1, r2, e;
    address = ADDR_DATA;
    tick();
    exp_q.push_back(32'hA); exp_q.push_back(32'hA); exp_q.push_back(32'h5);
    in_port = 4'h5;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front();
      n_tests++; if (bus1.readdata !== e) begin n_fail++; $display("FAIL data_latency[%0d]: got %h want %h", i, bus1.readdata, e); end
    end
    in_port = 4'hA;
    tick(4);
    bus_write(ADDR_EDGECAP, 32'hF);
    bus_read(ADDR_DATA, r1, r2);
    n_tests++; if (r1 !== 32'hA) begin n_fail++; $display("FAIL data_back: got %h want 0000000a", r1); end
  endtask

  task automatic test_reserved();
    logic [31:0] r1, r2;
    bus_write(ADDR_DATA, 32'h5);
    bus_read(ADDR_DATA, r1, r2);
    n_tests++; if (r1 !== 32'hA) begin n_fail++; $display("FAIL data_ro: got %h want 0000000a", r1); end
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, r1, r2);
    n_tests++; if (r1 !== 32'h0) begin n_fail++; $display("FAIL reserved: got %h want 0", r1); end
    bus_write(ADDR_IRQMASK, 32'hFFFF_FFFF);
    bus_read(ADDR_IRQMASK, r1, r2);
    n_tests++; if (r1 !== (EN ? 32'hF : 32'h0)) begin n_fail++; $display("FAIL irqmask_rw: got %h want %h", r1, (EN ? 32'hF : 32'h0)); end
    bus_write(ADDR_EDGECAP, 32'hF);
    bus_read(ADDR_EDGECAP, r1, r2);
    n_tests++; if (r1 !== 32'h0) begin n_fail++; $display("FAIL edgecap_w1c_empty: got %h want 0", r1); end
    bus_write(ADDR_IRQMASK, 32'h0);
  endtask

  task automatic test_rising_irq();
    logic [31:0] r1, r2;
    bus_write(ADDR_IRQMASK, 32'h4);
    in_port = 4'hE;
    tick(2);
    n_tests++; if (bus1.irq !== 1'b0) begin n_fail++; $display("FAIL rise_irq_early: got %b want 0", bus1.irq); end
    tick();
    n_tests++; if (bus1.irq !== EN) begin n_fail++; $display("FAIL rise_irq: got %b want %b", bus1.irq, EN); end
    bus_read(ADDR_EDGECAP, r1, r2);
    n_tests++; if (r1 !== (EN ? 32'h4 : 32'h0)) begin n_fail++; $display("FAIL rise_edgecap: got %h want %h", r1, (EN ? 32'h4 : 32'h0)); end
    bus_write(ADDR_EDGECAP, 32'h4);
    n_tests++; if (bus1.irq !== 1'b0) begin n_fail++; $display("FAIL rise_clear_irq: got %b want 0", bus1.irq); end
    bus_read(ADDR_EDGECAP, r1, r2);
    n_tests++; if (r1 !== 32'h0) begin n_fail++; $display("FAIL rise_clear_edgecap: got %h want 0", r1); end
  endtask

  task automatic test_masked();
    logic [31:0] r1, r2;
    bus_write(ADDR_IRQMASK, 32'h0);
    in_port = 4'hF;
    tick(3);
    bus_read(ADDR_EDGECAP, r1, r2);
    n_tests++; if (r1 !== (EN ? 32'h1 : 32'h0)) begin n_fail++; $display("FAIL masked_edgecap: got %h want %h", r1, (EN ? 32'h1 : 32'h0)); end
    n_tests++; if (bus1.irq !== 1'b0) begin n_fail++; $display("FAIL masked_irq: got %b want 0", bus1.irq); end
    bus_write(ADDR_IRQMASK, 32'h1);
    n_tests++; if (bus1.irq !== EN) begin n_fail++; $display("FAIL unmask_irq: got %b want %b", bus1.irq, EN); end
    bus_write(ADDR_EDGECAP, 32'h1);
    bus_write(ADDR_IRQMASK, 32'h0);
  endtask

  task automatic test_collision();
    logic [31:0] r1, r2;
    in_port = 4'hD;
    tick(4);
    bus_read(ADDR_EDGECAP, r1, r2);
    n_tests++; if (r1 !== 32'h0) begin n_fail++; $display("FAIL fall_ignored: got %h want 0", r1); end
    in_port = 4'hF;
    tick(2);
    bus_write(ADDR_EDGECAP, 32'h2);
    bus_read(ADDR_EDGECAP, r1, r2);
    n_tests++; if (r1 !== (EN ? 32'h2 : 32'h0)) begin n_fail++; $display("FAIL collision: got %h want %h", r1, (EN ? 32'h2 : 32'h0)); end
    bus_write(ADDR_EDGECAP, 32'h2);
    bus_read(ADDR_EDGECAP, r1, r2);
    n_tests++; if (r1 !== 32'h0) begin n_fail++; $display("FAIL collision_clear: got %h want 0", r1); end
  endtask

  task automatic test_any_edge();
    logic [31:0] r1, r2;
    bus_write(ADDR_EDGECAP, 32'hF);
    bus_read(ADDR_EDGECAP, r1, r2);
    n_tests++; if (r2 !== 32'h0) begin n_fail++; $display("FAIL any_start: got %h want 0", r2); end
    in_port = 4'h7;
    tick(3);
    bus_read(ADDR_EDGECAP, r1, r2);
    n_tests++; if (r2 !== (EN ? 32'h8 : 32'h0)) begin n_fail++; $display("FAIL any_fall: got %h want %h", r2, (EN ? 32'h8 : 32'h0)); end
    n_tests++; if (r1 !== 32'h0) begin n_fail++; $display("FAIL rise_on_fall: got %h want 0", r1); end
    bus_write(ADDR_EDGECAP, 32'h0);
    bus_read(ADDR_EDGECAP, r1, r2);
    n_tests++; if (r2 !== (EN ? 32'h8 : 32'h0)) begin n_fail++; $display("FAIL w1c_zero: got %h want %h", r2, (EN ? 32'h8 : 32'h0)); end
    bus_write(ADDR_EDGECAP, 32'h8);
    bus_read(ADDR_EDGECAP, r1, r2);
    n_tests++; if (r2 !== 32'h0) begin n_fail++; $display("FAIL any_clear: got %h want 0", r2); end
    in_port = 4'hF;
    tick(3);
    bus_read(ADDR_EDGECAP, r1, r2);
    n_tests++; if (r2 !== (EN ? 32'h8 : 32'h0)) begin n_fail++; $display("FAIL any_rise: got %h want %h", r2, (EN ? 32'h8 : 32'h0)); end
    n_tests++; if (r1 !== (EN ? 32'h8 : 32'h0)) begin n_fail++; $display("FAIL rise_bit3: got %h want %h", r1, (EN ? 32'h8 : 32'h0)); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] r1, r2;
    bus_write(ADDR_IRQMASK, 32'hF);
    n_tests++; if (bus1.irq !== EN) begin n_fail++; $display("FAIL midop_irq_before: got %b want %b", bus1.irq, EN); end
    address = ADDR_EDGECAP;
    tick();
    in_port = 4'hA;
    reset = 1'b1;
    #1;
    n_tests++; if (bus1.irq !== 1'b0) begin n_fail++; $display("FAIL midop_irq: got %b want 0", bus1.irq); end
    n_tests++; if (bus1.readdata !== 32'h0) begin n_fail++; $display("FAIL midop_readdata: got %h want 0", bus1.readdata); end
    tick(2);
    reset = 1'b0;
    tick(3);
    bus_read(ADDR_EDGECAP, r1, r2);
    n_tests++; if (r1 !== 32'h0 || r2 !== 32'h0) begin n_fail++; $display("FAIL midop_edgecap: got %h/%h want 0/0", r1, r2); end
    bus_read(ADDR_IRQMASK, r1, r2);
    n_tests++; if (r1 !== 32'h0) begin n_fail++; $display("FAIL midop_irqmask: got %h want 0", r1); end
    bus_read(ADDR_DATA, r1, r2);
    n_tests++; if (r1 !== 32'hA) begin n_fail++; $display("FAIL midop_data: got %h want 0000000a", r1); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_data_path();
    test_reserved();
    test_rising_irq();
    test_masked();
    test_collision();
    test_any_edge();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
